syn_lb_host_bridge: RTL and testbench
=====================================

// Module: syn_lb_host_bridge
// PURPOSE
//  Host-side master of the internal local bus: takes single read/write requests from the host command
//  front-end and drives them onto a syn_lb_intf.master port.
//  Returns read data and completion to the host; one transaction outstanding at a time.
//  Bounds every transaction with a timeout so that an unmapped address cannot hang the host.
// PARAMETERS
//  DATA_W      32    local bus / host data width
//  ADDR_W      8     local bus / host address width
//  TOUT_CYCLES 64    cycles after strobe before a transaction is aborted (>=2)
//  TOUT_RDATA  'hDEAD_BEEF  read data returned on timeout (truncated to DATA_W)
// PORTS
//  clk_ir      in   1       clock
//  rst_il      in   1       synchronous reset, active-high
//  host_req    in   1       request strobe, sampled only when host_busy=0
//  host_wr     in   1       1=write, 0=read (qualified by host_req)
//  host_addr   in   ADDR_W  request address
//  host_wdata  in   DATA_W  write data
//  host_busy   out  1       transaction in flight; new requests ignored
//  host_done   out  1       one-cycle completion pulse
//  host_rdata  out  DATA_W  read data, valid with host_done for reads, held until next done
//  host_err    out  1       timeout flag, valid with host_done
//  lb          intf master  syn_lb_intf.master (rd_en, wr_en, addr, wr_data / wr_valid, rd_valid, rd_data)
// BEHAVIOUR
//  Reset: all outputs 0 (host_busy, host_done, host_rdata, host_err, lb.rd_en, lb.wr_en, lb.addr,
//   lb.wr_data); FSM=IDLE; timeout counter=0. Reset mid-transaction aborts silently: no host_done.
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs registered.
//  IDLE:
//   - host_req=1 latches host_wr/host_addr/host_wdata into lb.addr/lb.wr_data.
//   - Next cycle: ISSUE, host_busy=1.
//  ISSUE (1 cycle):
//   - lb.wr_en=1 (write) or lb.rd_en=1 (read) for exactly this cycle; counter cleared.
//   - A matching response in this cycle completes the transaction -> DONE.
//   - Otherwise -> WAIT.
//  WAIT:
//   - lb.addr/lb.wr_data held stable; strobes 0; counter increments each cycle.
//   - Matching response: lb.wr_valid for a write, lb.rd_valid for a read (capture lb.rd_data)
//     -> DONE, host_err=0.
//   - Counter reaching TOUT_CYCLES-1 with no response -> DONE, host_err=1, host_rdata=TOUT_RDATA
//     for reads (unchanged for writes).
//   - Response and expiry in the same cycle: response wins, host_err=0.
//  DONE (1 cycle):
//   - host_done=1, host_busy=0 at this cycle's output. -> IDLE.
//   - Earliest next request is accepted in the DONE cycle's successor (IDLE).
//  Latency: host_req at cycle N -> strobe at N+1 -> host_done no earlier than N+2 (zero-latency slave),
//   at most N+1+TOUT_CYCLES.
//  Ignored inputs:
//   - Non-matching responses (rd_valid during a write, wr_valid during a read).
//   - Any valid while IDLE/DONE.
//   - host_req while busy.
//  host_err and host_rdata hold until the next host_done.
//  Counter width $clog2(TOUT_CYCLES)+1; no wrap possible before expiry.
// STRUCTURE
//  syn_lb_pkg: typedef enum {IDLE, ISSUE, WAIT, DONE} lb_brdg_st_t; LB_TOUT_RDATA default constant.
//  Single flat module; no sub-module (counter and FSM are <150 lines together).
// TESTING
//  1 write addr=0x10 data=0x1234_5678, slave wr_valid 3 cycles after wr_en -> one wr_en pulse,
//    lb.addr stable until done, host_done 1 cycle, host_err=0.
//  2 read addr=0x04, slave rd_valid with rd_data=0xCAFE_F00D in the ISSUE cycle -> host_done at N+2,
//    host_rdata=0xCAFE_F00D.
//  3 read to unmapped addr, no response -> host_done at N+1+64, host_err=1, host_rdata=0xDEAD_BEEF.
//  4 rd_valid arrives exactly on the expiry cycle -> host_err=0, captured rd_data returned.
//  5 host_req held high continuously plus stray wr_valid during a read -> strobe rejected only on match;
//    back-to-back transactions spaced by busy; stray wr_valid ignored.
//  6 rst_il asserted in WAIT -> next cycle all outputs 0, no host_done; a fresh read then completes normally.

Source files
------------

// File: rtl/syn_lb_host_bridge_pkg.sv
// syn_lb_pkg: shared types and constants for the local bus host bridge
package syn_lb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lb_brdg_st_t;
    localparam logic [31:0] LB_TOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/syn_lb_host_bridge_if.sv
// syn_lb_intf: internal local bus between a single master and the register slaves
interface syn_lb_intf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    modport master(output rd_en, wr_en, addr, wr_data, input wr_valid, rd_valid, rd_data);
    modport slave(input rd_en, wr_en, addr, wr_data, output wr_valid, rd_valid, rd_data);
endinterface

// File: rtl/syn_lb_host_bridge.sv
// syn_lb_host_bridge: host single-request master for the local bus, one transaction
// outstanding, every transaction bounded by a timeout
module syn_lb_host_bridge
    import syn_lb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 8,
    parameter int                TOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] TOUT_RDATA  = DATA_W'(LB_TOUT_RDATA)
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_busy,
    output logic              host_done,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    syn_lb_intf.master        lb
);
    localparam int CW = $clog2(TOUT_CYCLES) + 1;
    lb_brdg_st_t   st, st_n;
    logic          wr_q;
    logic [CW-1:0] cnt;
    logic          rsp;
    logic          tout;
    logic          fin;
    // counter starts at 0 in the strobe cycle, so expiry lands TOUT_CYCLES cycles after the strobe
    always_comb begin
        rsp  = wr_q ? lb.wr_valid : lb.rd_valid;
        tout = cnt == CW'(TOUT_CYCLES - 1);
        st_n = st;
        case (st)
            IDLE:    st_n = host_req ? ISSUE : IDLE;
            ISSUE:   st_n = rsp ? DONE : WAIT;
            WAIT:    st_n = (rsp || tout) ? DONE : WAIT;
            default: st_n = IDLE;
        endcase
        fin = (st == ISSUE || st == WAIT) && st_n == DONE;
    end
    always_ff @(posedge clk_ir) begin
        if (rst_il) st <= IDLE;
        else st <= st_n;
    end
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            wr_q       <= 1'b0;
            cnt        <= '0;
            host_busy  <= 1'b0;
            host_done  <= 1'b0;
            host_rdata <= '0;
            host_err   <= 1'b0;
            lb.rd_en   <= 1'b0;
            lb.wr_en   <= 1'b0;
            lb.addr    <= '0;
            lb.wr_data <= '0;
        end else begin
            lb.rd_en  <= st == IDLE && host_req && !host_wr;
            lb.wr_en  <= st == IDLE && host_req && host_wr;
            host_busy <= st_n == ISSUE || st_n == WAIT;
            host_done <= fin;
            cnt       <= st == IDLE ? '0 : cnt + 1'b1;
            if (st == IDLE && host_req) begin
                wr_q       <= host_wr;
                lb.addr    <= host_addr;
                lb.wr_data <= host_wdata;
            end
            // a response in the expiry cycle still wins over the timeout
            if (fin) begin
                host_err <= !rsp;
                if (!wr_q) host_rdata <= rsp ? lb.rd_data : TOUT_RDATA;
            end
        end
    end
endmodule

// File: tb/tb_syn_lb_host_bridge.sv
// tb_syn_lb_host_bridge: scoreboard bench for the local bus host bridge
module tb_syn_lb_host_bridge;
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_wr;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_busy, host_done, host_err;
    logic [31:0] host_rdata;
    int          vec = 0, errs = 0, cyc = 0;
    int          wr_pulses = 0, rd_pulses = 0;
    logic [31:0] last_rdata = 32'h0;
    exp_t        exp_q[$];

    syn_lb_intf #(.DATA_W(32), .ADDR_W(8)) lb();

    syn_lb_host_bridge #(.DATA_W(32), .ADDR_W(8), .TOUT_CYCLES(64)) dut (
        .clk_ir(clk), .rst_il(rst), .host_req(host_req), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_busy(host_busy),
        .host_done(host_done), .host_rdata(host_rdata), .host_err(host_err), .lb(lb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lb.wr_en) wr_pulses <= wr_pulses + 1;
        if (lb.rd_en) rd_pulses <= rd_pulses + 1;
    end

    function automatic exp_t mk(input logic err, input logic [31:0] rdata, input int dc);
        exp_t e;
        e.err = err;
        e.rdata = rdata;
        e.done_cyc = dc;
        return e;
    endfunction

    // drives a one-cycle request; returns at the negedge of the strobe cycle
    task automatic start(input logic wr, input logic [7:0] a, input logic [31:0] d, output int n);
        @(negedge clk);
        host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = d; n = cyc;
        @(negedge clk);
        host_req = 1'b0;
    endtask

    // slave valids are one-cycle pulses: cleared at each negedge passed here
    task automatic wait_done(output int dc, output bit ok);
        ok = 0; dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lb.rd_valid = 1'b0; lb.wr_valid = 1'b0;
            if (host_done) begin
                dc = cyc; ok = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if ({host_busy, host_done, host_err} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b exp 000", {host_busy, host_done, host_err}); end
        vec++; if (host_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h exp 0", host_rdata); end
        vec++; if ({lb.rd_en, lb.wr_en} !== 2'b00) begin errs++; $display("FAIL reset_strobes got %b exp 00", {lb.rd_en, lb.wr_en}); end
        vec++; if ({lb.addr, lb.wr_data} !== 40'h0) begin errs++; $display("FAIL reset_bus got %h exp 0", {lb.addr, lb.wr_data}); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        int n, dc, bad; bit ok; exp_t e;
        wr_pulses = 0; bad = 0;
        start(1'b1, 8'h10, 32'h1234_5678, n);
        exp_q.push_back(mk(1'b0, last_rdata, n + 5));
        vec++; if ({lb.wr_en, lb.rd_en, host_busy} !== 3'b101) begin errs++; $display("FAIL wr_issue got %b exp 101", {lb.wr_en, lb.rd_en, host_busy}); end
        vec++; if ({lb.addr, lb.wr_data} !== {8'h10, 32'h1234_5678}) begin errs++; $display("FAIL wr_bus got %h exp 101234_5678", {lb.addr, lb.wr_data}); end
        repeat (3) begin
            @(negedge clk);
            if (lb.addr !== 8'h10 || lb.wr_en !== 1'b0 || host_busy !== 1'b1 || host_done !== 1'b0) bad++;
        end
        vec++; if (bad !== 0) begin errs++; $display("FAIL wr_wait_stable got %0d bad cycles exp 0", bad); end
        lb.wr_valid = 1'b1;
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc) begin errs++; $display("FAIL wr_latency got %0d exp %0d", dc, e.done_cyc); end
        vec++; if (host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL wr_result got err=%b rdata=%h exp err=%b rdata=%h", host_err, host_rdata, e.err, e.rdata); end
        vec++; if (host_busy !== 1'b0) begin errs++; $display("FAIL wr_busy_at_done got %b exp 0", host_busy); end
        @(negedge clk);
        vec++; if (host_done !== 1'b0) begin errs++; $display("FAIL wr_done_pulse got %b exp 0", host_done); end
        vec++; if (wr_pulses !== 1) begin errs++; $display("FAIL wr_pulse_count got %0d exp 1", wr_pulses); end
    endtask

    task automatic test_read_fast();
        int n, dc; bit ok; exp_t e;
        start(1'b0, 8'h04, 32'h0, n);
        vec++; if ({lb.rd_en, lb.addr} !== {1'b1, 8'h04}) begin errs++; $display("FAIL rd_issue got %h exp 104", {lb.rd_en, lb.addr}); end
        lb.rd_valid = 1'b1; lb.rd_data = 32'hCAFE_F00D;
        last_rdata = 32'hCAFE_F00D;
        exp_q.push_back(mk(1'b0, last_rdata, n + 2));
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc) begin errs++; $display("FAIL rd_fast_latency got %0d exp %0d", dc, e.done_cyc); end
        vec++; if (host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL rd_fast_result got err=%b rdata=%h exp err=%b rdata=%h", host_err, host_rdata, e.err, e.rdata); end
    endtask

    task automatic test_write_timeout();
        int n, dc; bit ok; exp_t e;
        start(1'b1, 8'hE0, 32'h5555_AAAA, n);
        exp_q.push_back(mk(1'b1, last_rdata, n + 65));
        lb.rd_valid = 1'b1; lb.rd_data = 32'h0BAD_0BAD;
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc) begin errs++; $display("FAIL wr_tout_latency got %0d exp %0d", dc, e.done_cyc); end
        vec++; if (host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL wr_tout_result got err=%b rdata=%h exp err=%b rdata=%h", host_err, host_rdata, e.err, e.rdata); end
    endtask

    task automatic test_read_timeout();
        int n, dc; bit ok; exp_t e;
        start(1'b0, 8'hF3, 32'h0, n);
        last_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(mk(1'b1, last_rdata, n + 65));
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc) begin errs++; $display("FAIL rd_tout_latency got %0d exp %0d", dc, e.done_cyc); end
        vec++; if (host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL rd_tout_result got err=%b rdata=%h exp err=%b rdata=%h", host_err, host_rdata, e.err, e.rdata); end
        repeat (4) @(negedge clk);
        vec++; if (host_err !== 1'b1 || host_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rd_tout_hold got err=%b rdata=%h exp err=1 rdata=deadbeef", host_err, host_rdata); end
    endtask

    task automatic test_expiry_race();
        int n, dc; bit ok; exp_t e;
        start(1'b0, 8'h44, 32'h0, n);
        repeat (63) @(negedge clk);
        vec++; if (host_busy !== 1'b1 || host_done !== 1'b0) begin errs++; $display("FAIL race_pre got busy=%b done=%b exp busy=1 done=0", host_busy, host_done); end
        lb.rd_valid = 1'b1; lb.rd_data = 32'h0BAD_CAFE;
        last_rdata = 32'h0BAD_CAFE;
        exp_q.push_back(mk(1'b0, last_rdata, n + 65));
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc) begin errs++; $display("FAIL race_latency got %0d exp %0d", dc, e.done_cyc); end
        vec++; if (host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL race_result got err=%b rdata=%h exp err=%b rdata=%h", host_err, host_rdata, e.err, e.rdata); end
    endtask

    task automatic test_back_to_back();
        int n, dc; bit ok; exp_t e;
        rd_pulses = 0;
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h20; n = cyc;
        exp_q.push_back(mk(1'b0, 32'h1111_1111, n + 3));
        exp_q.push_back(mk(1'b0, 32'h2222_2222, n + 6));
        @(negedge clk);
        host_addr = 8'h21; lb.wr_valid = 1'b1;
        vec++; if (lb.rd_en !== 1'b1) begin errs++; $display("FAIL b2b_issue1 got %b exp 1", lb.rd_en); end
        @(negedge clk);
        lb.wr_valid = 1'b0; lb.rd_valid = 1'b1; lb.rd_data = 32'h1111_1111;
        vec++; if ({host_done, host_busy, lb.addr} !== {2'b01, 8'h20}) begin errs++; $display("FAIL b2b_stray_ignored got %h exp 120", {host_done, host_busy, lb.addr}); end
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc || host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL b2b_first got cyc=%0d err=%b rdata=%h exp cyc=%0d err=%b rdata=%h", dc, host_err, host_rdata, e.done_cyc, e.err, e.rdata); end
        @(negedge clk);
        vec++; if ({host_busy, lb.rd_en} !== 2'b00) begin errs++; $display("FAIL b2b_idle_gap got %b exp 00", {host_busy, lb.rd_en}); end
        @(negedge clk);
        vec++; if ({lb.rd_en, lb.addr} !== {1'b1, 8'h21}) begin errs++; $display("FAIL b2b_issue2 got %h exp 121", {lb.rd_en, lb.addr}); end
        lb.rd_valid = 1'b1; lb.rd_data = 32'h2222_2222; host_req = 1'b0;
        wait_done(dc, ok);
        e = exp_q.pop_front();
        last_rdata = e.rdata;
        vec++; if (!ok || dc !== e.done_cyc || host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL b2b_second got cyc=%0d err=%b rdata=%h exp cyc=%0d err=%b rdata=%h", dc, host_err, host_rdata, e.done_cyc, e.err, e.rdata); end
        vec++; if (rd_pulses !== 2) begin errs++; $display("FAIL b2b_pulse_count got %0d exp 2", rd_pulses); end
    endtask

    task automatic test_reset_in_wait();
        int n, dc, bad; bit ok; exp_t e;
        bad = 0;
        start(1'b1, 8'h30, 32'h7777_7777, n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++; if ({host_busy, host_done, host_err, lb.rd_en, lb.wr_en} !== 5'b0) begin errs++; $display("FAIL rst_wait_flags got %b exp 00000", {host_busy, host_done, host_err, lb.rd_en, lb.wr_en}); end
        vec++; if ({host_rdata, lb.addr, lb.wr_data} !== 72'h0) begin errs++; $display("FAIL rst_wait_data got %h exp 0", {host_rdata, lb.addr, lb.wr_data}); end
        repeat (70) begin
            @(negedge clk);
            if (host_done !== 1'b0 || host_busy !== 1'b0) bad++;
        end
        vec++; if (bad !== 0) begin errs++; $display("FAIL rst_wait_silent got %0d bad cycles exp 0", bad); end
        start(1'b0, 8'h31, 32'h0, n);
        @(negedge clk);
        lb.rd_valid = 1'b1; lb.rd_data = 32'h3C3C_3C3C;
        exp_q.push_back(mk(1'b0, 32'h3C3C_3C3C, n + 3));
        wait_done(dc, ok);
        e = exp_q.pop_front();
        vec++; if (!ok || dc !== e.done_cyc || host_err !== e.err || host_rdata !== e.rdata) begin errs++; $display("FAIL rst_fresh_read got cyc=%0d err=%b rdata=%h exp cyc=%0d err=%b rdata=%h", dc, host_err, host_rdata, e.done_cyc, e.err, e.rdata); end
    endtask

    initial begin
        rst = 1'b1; host_req = 1'b0; host_wr = 1'b0; host_addr = 8'h0; host_wdata = 32'h0;
        lb.rd_valid = 1'b0; lb.wr_valid = 1'b0; lb.rd_data = 32'h0;
        test_reset();
        test_write();
        test_read_fast();
        test_write_timeout();
        test_read_timeout();
        test_expiry_race();
        test_back_to_back();
        test_reset_in_wait();
        vec++; if (exp_q.size() !== 0) begin errs++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
